multicycle_alu: RTL and testbench
=================================

Name: multicycle_alu

Overview:
- Execute-stage ALU directly downstream of the ALU control decoder; consumes its 2-bit ALU function code.
- ADD, SUB and OR complete in one cycle.
- SHIFT is a logical left shift, one bit per cycle, sequenced by an internal FSM.
- A start/busy/done handshake lets the CPU control stall the datapath until the result is valid.

Parameters:
- WIDTH, 32, operand and result width.
- SHAMT_W, 5, shift-amount width; must equal log2(WIDTH).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  request; sampled on a rising edge only when busy=0.
- ALU_function  input  2  00=ADD, 01=SUB, 10=OR, 11=SHIFT (SLL).
- src1  input  WIDTH  operand A; also the shift source value.
- src2  input  WIDTH  operand B; ignored for SHIFT.
- shamt  input  SHAMT_W  shift amount; ignored unless SHIFT.
- result  output  WIDTH  registered result; holds until the next accepted start.
- zero  output  1  registered; 1 when result==0; updated together with result.
- overflow  output  1  registered signed overflow for ADD/SUB; 0 for OR/SHIFT.
- busy  output  1  1 while a shift is in progress; start is ignored.
- done  output  1  one-cycle pulse; result, zero and overflow are valid.

Behaviour:
- Clock and reset: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, result=0, zero=0, overflow=0, busy=0, done=0, shift counter=0.
- Reset mid-operation aborts immediately; no done pulse is issued.
- FSM states:
  - IDLE: busy=0, done=0.
  - SHIFT: busy=1, done=0.
  - DONE: busy=0, done=1, lasts exactly one cycle.
- Accept condition: start=1 at a rising edge in IDLE or DONE (back-to-back allowed). Operands, function and shamt are latched at that edge (call it edge N).
- Accept while in SHIFT: start is ignored. Input changes do not affect the operation in flight.
- ADD/SUB/OR, or SHIFT with shamt=0:
  - result, zero and overflow are written at edge N.
  - Next state is DONE, so done=1 in the cycle after edge N (latency 1).
  - SHIFT with shamt=0 gives result=src1.
- SHIFT with shamt=k>0:
  - At edge N: shift register=src1, counter=k, state=SHIFT.
  - Each subsequent edge: shift register <<= 1, zero fill, counter decrements.
  - At the edge where the counter goes from 1 to 0: result=shifted value, zero updated, overflow=0, state=DONE.
  - done is high in the cycle after edge N+k (latency k+1). Maximum latency is WIDTH cycles (k=31).
  - result output is not updated during SHIFT; it keeps the previous value until DONE.
- Arithmetic rules:
  - ADD and SUB are modulo 2^WIDTH.
  - SUB is src1 + ~src2 + 1.
  - ADD overflow: operands share a sign and the result sign differs.
  - SUB overflow: operand signs differ and the result sign differs from src1.
  - Carry-out is not exported.
- DONE exit: returns to IDLE unless a new start is accepted at that edge.
- If DONE accepts a new single-cycle op, done stays 1 for a second consecutive cycle with the new result.

Decomposition:
- Package alu_pkg holds:
  - ALU function codes: ALU_ADD=2'b00, ALU_SUB=2'b01, ALU_OR=2'b10, ALU_SHIFT=2'b11. These are the same encoding the ALU control block emits.
  - FSM state encoding: IDLE, SHIFT, DONE.
- Sub-module alu_core: purely combinational ADD/SUB/OR with result and overflow outputs. It is reused by a future pipelined ALU.
- multicycle_alu owns the FSM, shift register, counter and output registers.

Test Plan:
- Reset: assert rst_n=0 mid-shift (shamt=20, cycle 5) -> busy=0, done=0, result=0 immediately; no done pulse follows after release.
- ADD overflow: ADD 0x7FFFFFFF + 0x00000001 -> done one cycle after start; result=0x80000000, overflow=1, zero=0.
- SUB zero: SUB 5 - 5 -> result=0, zero=1, overflow=0. Then SUB 0x80000000 - 1 -> result=0x7FFFFFFF, overflow=1.
- Shift latency: SHIFT src1=0x00000001, shamt=31 -> busy=1 for 31 cycles, done 32 cycles after start, result=0x80000000. shamt=0 on src1=0xA5 -> done after 1 cycle, result=0xA5.
- Ignored start: issue start with OR 0xF0|0x0F while SHIFT src1=0x3, shamt=4 is busy -> OR ignored; result=0x30 at done.
- Back-to-back ops: OR 0xF0|0x0F asserted in the DONE cycle of a previous ADD -> done high two consecutive cycles; second result=0xFF, zero=0.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Brief    : ALU function codes and multicycle ALU FSM state encoding
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // Same encoding as the ALU control decoder output
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_OR    = 2'b10;
    localparam logic [1:0] ALU_SHIFT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// ============================================================================
// Module   : alu_core
// Brief    : Combinational ADD/SUB/OR with signed overflow detection
// Revision : 1.0 - initial release
// ============================================================================
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [1:0]       func_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] result_o,
    output logic             overflow_o
);

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;

    assign sum  = a_i + b_i;
    assign diff = a_i + ~b_i + {{(WIDTH-1){1'b0}}, 1'b1};

    always_comb begin
        result_o   = '0;
        overflow_o = 1'b0;
        case (func_i)
            ALU_ADD: begin
                result_o   = sum;
                overflow_o = (a_i[WIDTH-1] == b_i[WIDTH-1]) &&
                             (sum[WIDTH-1] != a_i[WIDTH-1]);
            end
            ALU_SUB: begin
                result_o   = diff;
                overflow_o = (a_i[WIDTH-1] != b_i[WIDTH-1]) &&
                             (diff[WIDTH-1] != a_i[WIDTH-1]);
            end
            ALU_OR:  result_o = a_i | b_i;
            default: result_o = '0;
        endcase
    end

endmodule : alu_core
`default_nettype wire

// File: rtl/multicycle_alu.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_alu
// Brief    : Execute-stage ALU; single-cycle ADD/SUB/OR, bit-serial SLL
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_alu
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [1:0]         ALU_function,
    input  logic [WIDTH-1:0]   src1,
    input  logic [WIDTH-1:0]   src2,
    input  logic [SHAMT_W-1:0] shamt,
    output logic [WIDTH-1:0]   result,
    output logic               zero,
    output logic               overflow,
    output logic               busy,
    output logic               done
);

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     shreg_q, shreg_d;
    logic [SHAMT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic                 zero_q, zero_d;
    logic                 ovf_q, ovf_d;

    logic [WIDTH-1:0]     core_result;
    logic                 core_ovf;
    logic                 accept;
    logic [WIDTH-1:0]     shifted;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .func_i     (ALU_function),
        .a_i        (src1),
        .b_i        (src2),
        .result_o   (core_result),
        .overflow_o (core_ovf)
    );

    assign accept  = start && (state_q != ST_SHIFT);
    assign shifted = shreg_q << 1;

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        if (accept) begin
            if (ALU_function != ALU_SHIFT) begin
                result_d = core_result;
                zero_d   = (core_result == '0);
                ovf_d    = core_ovf;
                state_d  = ST_DONE;
            end else if (shamt == '0) begin
                result_d = src1;
                zero_d   = (src1 == '0);
                ovf_d    = 1'b0;
                state_d  = ST_DONE;
            end else begin
                shreg_d  = src1;
                cnt_d    = shamt;
                state_d  = ST_SHIFT;
            end
        end else if (state_q == ST_SHIFT) begin
            shreg_d = shifted;
            cnt_d   = cnt_q - 1'b1;
            // Final step: publish the shifted value together with its flags
            if (cnt_q == SHAMT_W'(1)) begin
                result_d = shifted;
                zero_d   = (shifted == '0);
                ovf_d    = 1'b0;
                state_d  = ST_DONE;
            end
        end else if (state_q == ST_DONE) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            shreg_q  <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
        end
    end

    assign result   = result_q;
    assign zero     = zero_q;
    assign overflow = ovf_q;
    assign busy     = (state_q == ST_SHIFT);
    assign done     = (state_q == ST_DONE);

endmodule : multicycle_alu
`default_nettype wire

// File: tb/tb_multicycle_alu.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_alu
// Brief    : Directed and random checks of multicycle_alu against a model
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_alu;

    localparam logic [1:0] F_ADD = 2'b00;
    localparam logic [1:0] F_SUB = 2'b01;
    localparam logic [1:0] F_OR  = 2'b10;
    localparam logic [1:0] F_SLL = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  ALU_function = 2'b00;
    logic [31:0] src1 = '0;
    logic [31:0] src2 = '0;
    logic [4:0]  shamt = '0;
    logic [31:0] result;
    logic        zero, overflow, busy, done;

    int n_assert = 0;
    int n_fail   = 0;
    logic [31:0] last_r = '0;

    multicycle_alu #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .ALU_function (ALU_function),
        .src1         (src1),
        .src2         (src2),
        .shamt        (shamt),
        .result       (result),
        .zero         (zero),
        .overflow     (overflow),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: exact signed arithmetic; overflow whenever the wrapped
    // result no longer equals the mathematically true value.
    task automatic model(input logic [1:0] f, input logic [31:0] a, b,
                         input logic [4:0] sh, output logic [31:0] r,
                         output logic o, output int lat);
        longint t;
        r = '0; o = 1'b0; lat = 1; t = 0;
        case (f)
            F_ADD: begin
                t = longint'($signed(a)) + longint'($signed(b));
                r = a + b;
                o = (t != longint'($signed(r)));
            end
            F_SUB: begin
                t = longint'($signed(a)) - longint'($signed(b));
                r = a - b;
                o = (t != longint'($signed(r)));
            end
            F_OR:    r = a | b;
            default: begin
                r   = a << sh;
                lat = int'(sh) + 1;
            end
        endcase
    endtask

    task automatic wait_done(input string tag, input logic [31:0] exp_r, input logic exp_o,
                             input int exp_lat);
        int cycles   = 0;
        int busy_cnt = 0;
        logic held   = 1'b1;
        do begin
            @(negedge clk);
            cycles++;
            if (busy) busy_cnt++;
            if (!done && result !== last_r) held = 1'b0;
        end while (!done && cycles < 40);
        check({tag, " latency"},  cycles,   exp_lat);
        check({tag, " busy"},     busy_cnt, exp_lat - 1);
        check({tag, " held"},     {31'd0, held}, 32'd1);
        check({tag, " result"},   result,   exp_r);
        check({tag, " zero"},     {31'd0, zero},     {31'd0, exp_r == 32'd0});
        check({tag, " overflow"}, {31'd0, overflow}, {31'd0, exp_o});
        last_r = exp_r;
    endtask

    task automatic issue(input logic [1:0] f, input logic [31:0] a, b, input logic [4:0] sh);
        @(negedge clk);
        ALU_function = f; src1 = a; src2 = b; shamt = sh; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [1:0] f, input logic [31:0] a, b,
                          input logic [4:0] sh);
        logic [31:0] r; logic o; int lat;
        model(f, a, b, sh, r, o, lat);
        issue(f, a, b, sh);
        wait_done(tag, r, o, lat);
    endtask

    initial begin
        logic [31:0] r; logic o; int lat; int pulses;
        logic [1:0] rf; logic [31:0] ra, rb; logic [4:0] rs;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst result", result, 32'd0);
        check("rst flags", {28'd0, zero, overflow, busy, done}, 32'd0);
        @(negedge clk) rst_n = 1'b1;

        run_op("add ovf",  F_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0);
        run_op("sub zero", F_SUB, 32'd5, 32'd5, 5'd0);
        run_op("sub ovf",  F_SUB, 32'h8000_0000, 32'd1, 5'd0);
        run_op("sll 31",   F_SLL, 32'h0000_0001, 32'hDEAD_BEEF, 5'd31);
        run_op("sll 0",    F_SLL, 32'h0000_00A5, 32'h1234_5678, 5'd0);

        // Start pulses during a shift must be ignored
        issue(F_SLL, 32'h3, 32'h0, 5'd4);
        @(negedge clk);
        ALU_function = F_OR; src1 = 32'hF0; src2 = 32'h0F; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        begin
            int cycles = 2;
            while (!done && cycles < 40) begin @(negedge clk); cycles++; end
            check("ign latency", cycles, 5);
        end
        check("ign result", result, 32'h30);
        last_r = 32'h30;

        // Back-to-back: new op accepted in the DONE cycle
        issue(F_ADD, 32'd10, 32'd20, 5'd0);
        @(negedge clk);
        check("b2b first done", {31'd0, done}, 32'd1);
        check("b2b first result", result, 32'd30);
        ALU_function = F_OR; src1 = 32'hF0; src2 = 32'h0F; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("b2b second done", {31'd0, done}, 32'd1);
        check("b2b second result", result, 32'hFF);
        check("b2b second zero", {31'd0, zero}, 32'd0);
        @(negedge clk);
        check("b2b idle", {31'd0, done}, 32'd0);
        last_r = 32'hFF;

        // Reset mid-shift aborts at once with no later done
        issue(F_SLL, 32'h1, 32'h0, 5'd20);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid rst busy", {31'd0, busy}, 32'd0);
        check("mid rst done", {31'd0, done}, 32'd0);
        check("mid rst result", result, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        pulses = 0;
        repeat (30) begin @(negedge clk); if (done || busy) pulses++; end
        check("mid rst no done", pulses, 0);
        last_r = 32'd0;

        // Random operations
        for (int i = 0; i < 40; i++) begin
            rf = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            rs = 5'($urandom_range(0, 31));
            if (i % 8 == 0) rb = ra;
            model(rf, ra, rb, rs, r, o, lat);
            issue(rf, ra, rb, rs);
            wait_done($sformatf("rnd%0d f%0d", i, rf), r, o, lat);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_multicycle_alu
`default_nettype wire
